// File: rtl/mult_pkg.sv
// Shared widths and controller state encodings for the signed sequential multiplier.
package mult_pkg;

  localparam int unsigned OP_W   = 9;
  localparam int unsigned RES_W  = 17;
  localparam int unsigned ACC_W  = 18;
  localparam int unsigned ITER_N = 9;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ST_W   = 4;

  typedef enum logic [ST_W-1:0] {
    StIdle = 4'd0,
    StLoad = 4'd1,
    StIter = 4'd2,
    StSign = 4'd3,
    StDone = 4'd4
  } state_t;

endpackage

// File: rtl/signed_seq_multiplier_if.sv
// Start/operand request and result/status signals of the multiplier.
interface signed_seq_multiplier_if;
  import mult_pkg::*;

  logic             start;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic [RES_W-1:0] res;
  logic             done;
  logic             busy;
  logic             ovf;
  logic [ST_W-1:0]  state;

  modport master (
    output start, a, b,
    input  res, done, busy, ovf, state
  );

  modport slave (
    input  start, a, b,
    output res, done, busy, ovf, state
  );

endinterface

// File: rtl/mult_datapath.sv
// Operand capture, magnitude shift-add accumulation and signed result/overflow registers.
module mult_datapath
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_capture,
  input  logic             i_load,
  input  logic             i_iter,
  input  logic             i_sign,
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic             o_cnt_last,
  output logic [RES_W-1:0] o_res,
  output logic             o_ovf
);

  logic [OP_W-1:0]  r_op_a, r_op_b, r_mag_a, r_mag_b;
  logic             r_neg;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_res;
  logic             r_ovf;

  logic [OP_W-1:0]  w_mag_a, w_mag_b;
  logic [ACC_W-1:0] w_addend;
  logic [RES_W-1:0] w_acc_lo;

  // Unsigned 9-bit magnitude: -256 maps to 9'h100 (256).
  assign w_mag_a    = r_op_a[OP_W-1] ? -r_op_a : r_op_a;
  assign w_mag_b    = r_op_b[OP_W-1] ? -r_op_b : r_op_b;
  assign w_addend   = {{(ACC_W-OP_W){1'b0}}, r_mag_a} << r_cnt;
  assign w_acc_lo   = r_acc[RES_W-1:0];
  assign o_cnt_last = (r_cnt == CNT_W'(ITER_N - 1));
  assign o_res      = r_res;
  assign o_ovf      = r_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_capture) begin
        r_op_a <= i_a;
        r_op_b <= i_b;
      end
      if (i_load) begin
        r_mag_a <= w_mag_a;
        r_mag_b <= w_mag_b;
        r_neg   <= r_op_a[OP_W-1] ^ r_op_b[OP_W-1];
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (i_iter) begin
        if (r_mag_b[0]) begin
          r_acc <= r_acc + w_addend;
        end
        r_mag_b <= r_mag_b >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (i_sign) begin
        // Truncation commutes with negation, so negating the low 17 bits suffices.
        r_res <= r_neg ? -w_acc_lo : w_acc_lo;
        r_ovf <= !r_neg && (r_acc[ACC_W-1:RES_W-1] != '0);
      end
    end
  end

endmodule

// File: rtl/signed_seq_multiplier.sv
// Controller FSM for the 9x9 signed sequential multiplier; decodes busy/done from state.
module signed_seq_multiplier
  import mult_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  signed_seq_multiplier_if.slave   bus
);

  state_t r_state, w_state_next;
  logic   w_capture, w_load, w_iter, w_sign, w_cnt_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_load       = 1'b0;
    w_iter       = 1'b0;
    w_sign       = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_capture    = 1'b1;
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        w_load       = 1'b1;
        w_state_next = StIter;
      end
      StIter: begin
        w_iter = 1'b1;
        if (w_cnt_last) begin
          w_state_next = StSign;
        end
      end
      StSign: begin
        w_sign       = 1'b1;
        w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  mult_datapath u_datapath (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_capture  (w_capture),
    .i_load     (w_load),
    .i_iter     (w_iter),
    .i_sign     (w_sign),
    .i_a        (bus.a),
    .i_b        (bus.b),
    .o_cnt_last (w_cnt_last),
    .o_res      (bus.res),
    .o_ovf      (bus.ovf)
  );

  assign bus.state = r_state;
  assign bus.busy  = (r_state == StLoad) || (r_state == StIter) || (r_state == StSign);
  assign bus.done  = (r_state == StDone);

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Scoreboard bench: stimulus pushes hand-computed products, a monitor checks them on done.
module tb_signed_seq_multiplier;

  logic clock;
  logic reset_n;

  signed_seq_multiplier_if bus ();

  signed_seq_multiplier dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int n_done  = 0;
  logic [17:0] sb[$];  // {ovf, res}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset_n && bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [17:0] e;
        e = sb.pop_front();
        chk("res", 32'(bus.res), 32'(e[16:0]));
        chk("ovf", 32'(bus.ovf), 32'(e[17]));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  // Drive a request before edge k; returns at the negedge after k with start released.
  task automatic start_op(input logic [8:0] a, input logic [8:0] b,
                          input logic [16:0] exp_res, input logic exp_ovf, input bit push);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    if (push) sb.push_back({exp_ovf, exp_res});
    @(negedge clock);
    bus.start = 1'b0;
    bus.a     = 9'h0AA;
    bus.b     = 9'h155;
    chk("busy_in_load", 32'(bus.busy), 32'd1);
    chk("state_load", 32'(bus.state), 32'd1);
  endtask

  // Wait for done (bounded) and check the negedge count since acceptance.
  task automatic wait_done(input string name, input int lat, input int elapsed);
    int i;
    i = elapsed;
    while (bus.done !== 1'b1 && i < 40) begin
      @(negedge clock);
      i++;
    end
    chk(name, 32'(i), 32'(lat));
    @(negedge clock);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("state_idle_after", 32'(bus.state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #23;
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    reset_n = 1'b1;

    // Directed signed products.
    start_op(9'h1FF, 9'h1FF, 17'h00001, 1'b0, 1'b1); wait_done("lat_m1_m1", 11, 0);
    start_op(9'd7,   9'h1FD, 17'h1FFEB, 1'b0, 1'b1); wait_done("lat_7_m3", 11, 0);
    start_op(9'd255, 9'd255, 17'h0FE01, 1'b0, 1'b1); wait_done("lat_255_255", 11, 0);
    start_op(9'h100, 9'd255, 17'h10100, 1'b0, 1'b1); wait_done("lat_m256_255", 11, 0);
    start_op(9'h100, 9'h100, 17'h10000, 1'b1, 1'b1); wait_done("lat_m256_m256", 11, 0);
    start_op(9'h100, 9'd1,   17'h1FF00, 1'b0, 1'b1); wait_done("lat_m256_1", 11, 0);

    // Zero operand; a second start during ITER must be ignored.
    start_op(9'd0, 9'h1FF, 17'h00000, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    bus.start = 1'b1;
    bus.a     = 9'd3;
    bus.b     = 9'd3;
    @(negedge clock);
    bus.start = 1'b0;
    wait_done("lat_zero", 11, 5);
    d0 = n_done;
    repeat (15) @(negedge clock);
    chk("no_extra_done", 32'(n_done - d0), 32'd0);
    chk("idle_after_ignore", 32'(bus.state), 32'd0);

    // Nonzero result first so the asynchronous clear is observable.
    start_op(9'd5, 9'd6, 17'd30, 1'b0, 1'b1); wait_done("lat_5_6", 11, 0);
    start_op(9'd7, 9'd3, 17'd0, 1'b0, 1'b0);
    repeat (5) @(negedge clock);
    chk("iter_before_rst", 32'(bus.state), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_res", 32'(bus.res), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_state", 32'(bus.state), 32'd0);
    @(negedge clock);
    #1 reset_n = 1'b1;
    start_op(9'h1FB, 9'd9, 17'h1FFD3, 1'b0, 1'b1); wait_done("lat_after_rst", 11, 0);

    // Start held high: three back-to-back operations, done every 13 clocks.
    for (int k = 0; k < 3; k++) sb.push_back({1'b0, 17'd15});
    @(negedge clock);
    bus.start = 1'b1;
    bus.a     = 9'd3;
    bus.b     = 9'd5;
    @(negedge clock);
    wait_done("b2b_first", 11, 0);
    wait_done("b2b_second", 13, 1);
    begin
      int i;
      i = 1;
      while (bus.done !== 1'b1 && i < 40) begin
        @(negedge clock);
        i++;
      end
      bus.start = 1'b0;
      chk("b2b_third", 32'(i), 32'd13);
    end
    repeat (20) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/signed_seq_multiplier.md
Name: signed_seq_multiplier

Overview:
Sequential 9-bit x 9-bit two's-complement multiplier built as a controller FSM plus a shift-add datapath. It converts the operands to magnitudes and forms an unsigned shift-add product over 9 iterations. It then applies the sign (a[8] XOR b[8]) and presents a 17-bit two's-complement result. It is a standalone arithmetic block driven by a start strobe and polled via busy/done.

Parameters:
none (widths fixed: operands 9 bits, result 17 bits)

Ports:
clock    input   1   rising-edge system clock
reset_n  input   1   asynchronous active-low reset
start    input   1   request a multiplication; sampled only in IDLE
a        input   9   multiplicand, two's complement
b        input   9   multiplier, two's complement
res      output  17  product, two's complement; held stable between operations
done     output  1   one-cycle pulse when res is updated
busy     output  1   high from the cycle after start is accepted until done
ovf      output  1   high with done when the exact product does not fit 17 bits
state    output  4   current FSM state encoding, for debug

Behaviour:
- One clock domain; asynchronous active-low reset. While reset_n=0 all registers clear:
  - state=IDLE, res=0, done=0, busy=0, ovf=0
  - accumulator, magnitude registers and counter all 0
- FSM states and encodings: IDLE=4'd0, LOAD=4'd1, ITER=4'd2, SIGN=4'd3, DONE=4'd4. Other encodings go to IDLE.
- IDLE: if start=1 at a rising edge, register a and b into op_a and op_b, then go to LOAD. Otherwise stay. start is level-sampled; no edge detection.
- LOAD (1 cycle):
  - mag_a=|op_a| and mag_b=|op_b|, each 9 bits unsigned, so -256 gives 256.
  - neg = op_a[8] XOR op_b[8].
  - acc (18 bits) = 0, cnt = 0. Go to ITER.
- ITER (exactly 9 cycles), each cycle:
  - if mag_b[0], acc = acc + (mag_a << cnt)
  - mag_b shifts right by 1; cnt increments
  - after the cycle where cnt becomes 9, go to SIGN. A right-shift-accumulator formulation is equally acceptable if results match.
- SIGN (1 cycle):
  - res = neg ? -(acc) truncated to 17 bits : acc[16:0]
  - ovf = 1 only when acc > 65535 with neg=0, which occurs only for (-256)*(-256); res then wraps to 17'h10000.
  - Go to DONE.
- DONE (1 cycle): done=1, then return to IDLE unconditionally. A start present during DONE is ignored; it is sampled again in IDLE.
- busy=1 in LOAD, ITER and SIGN.
- Latency: start accepted at edge k, done high during the cycle after edge k+11 (12 clocks total).
- start during LOAD/ITER/SIGN/DONE is ignored. a and b may change freely after the accepting edge.
- res and ovf keep their last value until the next SIGN.
- Reset mid-operation: abort immediately and return to the reset values above. No partial result is visible.
- Zero operands: result 0, neg ignored. -0 is not representable, so res=0.

Decomposition:
- Shared package mult_pkg holds:
  - state typedef and encodings (IDLE..DONE)
  - OP_W=9, RES_W=17, ACC_W=18, ITER_N=9
- One sub-module is natural: mult_datapath, containing the operand/magnitude registers, acc, cnt, negation and the res/ovf registers. It is steered by control strobes (load, iter, sign) and returns cnt_done.
- The top level holds the FSM and the busy/done decode.

Test Plan:
- a=9'h1FF (-1), b=9'h1FF (-1), start held high for 1 cycle -> after 12 clocks done pulses, res=17'h00001, ovf=0, busy low.
- a=9'd7, b=9'h1FD (-3) -> res=17'h1FFEB (-21), ovf=0; a=9'd255, b=9'd255 -> res=17'd65025.
- a=9'h100 (-256), b=9'd255 -> res=-65280 (17'h10100), ovf=0; a=b=9'h100 -> res=17'h10000, ovf=1.
- a=0, b=9'h1FF -> res=0; then start pulsed again during ITER with other operands -> ignored, res still from first operation, one done pulse only.
- Start accepted, reset_n pulled low at ITER cycle 4 -> res=0, done=0, busy=0, state=IDLE immediately (asynchronously). After release, a new start completes normally in 12 clocks.
- start held high continuously with a=3, b=5 -> back-to-back operations. Each takes 12 clocks + 1 IDLE cycle and gives res=15; done pulses every 13 clocks.
